stream_min_max: RTL and testbench

Streaming signed min/max reducer for the datapath's compare path. Accepts a valid/ready stream of two's-complement N-bit samples grouped into packets by a `in_last` flag. Feeds each sample and the running extremes through two `comparator_lt` instances, and emits one {min, max, count} result per packet on a valid/ready output port. Sits directly downstream of the signed less-than comparator and is its first sequential consumer.

---
 rtl/stream_min_max.sv | 125 ++++++++++++
 tb/tb_stream_min_max.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_min_max.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_min_max : per-packet signed min/max/count reducer (valid/ready)    |
// | comparator_lt  : signed less-than used for all magnitude decisions        |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+

module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   // Sign-extended difference cannot overflow, so its top bit is signed(a < b).
   logic [N:0] w_diff;

   assign w_diff = {a[N-1], a} - {b[N-1], b};
   assign lt     = w_diff[N];
endmodule

module stream_min_max #(
   parameter int N = 32,
   parameter int C = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [N-1:0] out_min,
   output logic [N-1:0] out_max,
   output logic [C-1:0] out_count,
   output logic         out_valid,
   input  logic         out_ready
);
   typedef enum logic [1:0] {
      S_FIRST = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next;
   logic [N-1:0] r_min;
   logic [N-1:0] r_max;
   logic [C-1:0] r_count;
   logic         w_in_xfer;
   logic         w_out_xfer;
   logic         w_new_min;
   logic         w_new_max;

   assign in_ready   = ~rst & (r_state != S_DONE);
   assign out_valid  = (r_state == S_DONE);
   assign out_min    = r_min;
   assign out_max    = r_max;
   assign out_count  = r_count;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   comparator_lt #(.N(N)) u_cmp_min (
      .a  (in_data),
      .b  (r_min),
      .lt (w_new_min)
   );

   comparator_lt #(.N(N)) u_cmp_max (
      .a  (r_max),
      .b  (in_data),
      .lt (w_new_max)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FIRST;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FIRST, S_ACCUM: begin
            if (w_in_xfer) begin
               w_next = in_last ? S_DONE : S_ACCUM;
            end
         end
         S_DONE: begin
            if (w_out_xfer) begin
               w_next = S_FIRST;
            end
         end
         default: w_next = S_FIRST;
      endcase
   end

   // First sample of a packet seeds both extremes; later ones only replace on strict order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_min   <= '0;
         r_max   <= '0;
         r_count <= '0;
      end else if (w_in_xfer) begin
         if (r_state == S_FIRST) begin
            r_min   <= in_data;
            r_max   <= in_data;
            r_count <= C'(1);
         end else begin
            if (w_new_min) begin
               r_min <= in_data;
            end
            if (w_new_max) begin
               r_max <= in_data;
            end
            if (~&r_count) begin
               r_count <= r_count + C'(1);
            end
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_stream_min_max.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stream_min_max : vectors, corner sequences and random packets vs model |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+

module tb_stream_min_max;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [31:0] a_out_min, a_out_max, b_out_min, b_out_max;
   logic [15:0] a_out_count;
   logic [3:0]  b_out_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stream_min_max #(.N(32), .C(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (a_in_ready),
      .out_min   (a_out_min),
      .out_max   (a_out_max),
      .out_count (a_out_count),
      .out_valid (a_out_valid),
      .out_ready (out_ready)
   );

   stream_min_max #(.N(32), .C(4)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (b_in_ready),
      .out_min   (b_out_min),
      .out_max   (b_out_max),
      .out_count (b_out_count),
      .out_valid (b_out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      int          len;
      logic [31:0] d [8];
      logic [31:0] emin;
      logic [31:0] emax;
      int          ecnt;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic l, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = $urandom;
         in_last  = 1'($urandom);
         tick();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      t = 0;
      while (!a_in_ready && t < 100) begin
         tick();
         t++;
      end
      chk("push ready", 64'(a_in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input string name, input logic [31:0] emin, input logic [31:0] emax,
                             input int e16, input int e4, input int hold);
      int t = 0;
      while (!a_out_valid && t < 50) begin
         tick();
         t++;
      end
      chk({name, " valid"}, 64'(a_out_valid), 64'd1);
      if (!a_out_valid) return;
      chk({name, " valid_sat"}, 64'(b_out_valid), 64'd1);
      chk({name, " ready_low"}, 64'(a_in_ready), 64'd0);
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int h = 0; h < hold; h++) begin
            tick();
            chk({name, " hold valid"}, 64'(a_out_valid), 64'd1);
            chk({name, " hold ready"}, 64'(a_in_ready), 64'd0);
            chk({name, " hold min"}, 64'(a_out_min), 64'(emin));
            chk({name, " hold max"}, 64'(a_out_max), 64'(emax));
         end
      end
      chk({name, " min"}, 64'(a_out_min), 64'(emin));
      chk({name, " max"}, 64'(a_out_max), 64'(emax));
      chk({name, " count"}, 64'(a_out_count), 64'(e16));
      chk({name, " min_sat"}, 64'(b_out_min), 64'(emin));
      chk({name, " count_sat"}, 64'(b_out_count), 64'(e4));
      out_ready = 1'b1;
      tick();
      chk({name, " valid_drop"}, 64'(a_out_valid), 64'd0);
      chk({name, " ready_back"}, 64'(a_in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] s [$];
      logic signed [31:0] mn, mx;
      int len, sat;

      tbl[0].len = 5;
      tbl[0].d[0] = 32'd5;  tbl[0].d[1] = 32'hFFFF_FFFD; tbl[0].d[2] = 32'd17;
      tbl[0].d[3] = 32'd0;  tbl[0].d[4] = 32'hFFFF_FFFD;
      tbl[0].emin = 32'hFFFF_FFFD; tbl[0].emax = 32'd17; tbl[0].ecnt = 5;
      tbl[1].len = 2;
      tbl[1].d[0] = 32'h7FFF_FFFF; tbl[1].d[1] = 32'h8000_0000;
      tbl[1].emin = 32'h8000_0000; tbl[1].emax = 32'h7FFF_FFFF; tbl[1].ecnt = 2;
      tbl[2].len = 1;
      tbl[2].d[0] = 32'hFFFF_FFFF;
      tbl[2].emin = 32'hFFFF_FFFF; tbl[2].emax = 32'hFFFF_FFFF; tbl[2].ecnt = 1;
      tbl[3].len = 3;
      tbl[3].d[0] = 32'h8000_0000; tbl[3].d[1] = 32'h7FFF_FFFF; tbl[3].d[2] = 32'd0;
      tbl[3].emin = 32'h8000_0000; tbl[3].emax = 32'h7FFF_FFFF; tbl[3].ecnt = 3;
      tbl[4].len = 3;
      tbl[4].d[0] = 32'hFFFF_FFFB; tbl[4].d[1] = 32'hFFFF_FFFB; tbl[4].d[2] = 32'hFFFF_FFFB;
      tbl[4].emin = 32'hFFFF_FFFB; tbl[4].emax = 32'hFFFF_FFFB; tbl[4].ecnt = 3;
      tbl[5].len = 6;
      tbl[5].d[0] = 32'd10; tbl[5].d[1] = 32'd9;  tbl[5].d[2] = 32'd8;
      tbl[5].d[3] = 32'd7;  tbl[5].d[4] = 32'd11; tbl[5].d[5] = 32'd1;
      tbl[5].emin = 32'd1;  tbl[5].emax = 32'd11; tbl[5].ecnt = 6;

      // Reset values
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
      tick();
      chk("rst in_ready", 64'(a_in_ready), 64'd0);
      tick();
      chk("rst valid", 64'(a_out_valid), 64'd0);
      chk("rst min", 64'(a_out_min), 64'd0);
      chk("rst max", 64'(a_out_max), 64'd0);
      chk("rst count", 64'(a_out_count), 64'd0);
      chk("rst in_ready2", 64'(a_in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("post-rst in_ready", 64'(a_in_ready), 64'd1);

      // Table vectors, back-to-back samples, latency of one cycle after last
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < tbl[v].len; i++)
            push(tbl[v].d[i], i == tbl[v].len - 1, 0);
         chk($sformatf("vec%0d latency", v), 64'(a_out_valid), 64'd1);
         get_result($sformatf("vec%0d", v), tbl[v].emin, tbl[v].emax,
                    tbl[v].ecnt, tbl[v].ecnt, 0);
      end

      // Backpressure, then no carry-over into next packet
      push(32'd3, 1'b0, 0);
      push(32'hFFFF_FFF7, 1'b1, 0);
      get_result("bp", 32'hFFFF_FFF7, 32'd3, 2, 2, 10);
      push(32'd50, 1'b1, 0);
      get_result("bp next", 32'd50, 32'd50, 1, 1, 0);

      // Reset mid-packet discards partial packet
      push(32'd100, 1'b0, 0);
      push(32'd200, 1'b0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst valid", 64'(a_out_valid), 64'd0);
      push(32'hFFFF_FFF9, 1'b1, 1);
      get_result("midrst", 32'hFFFF_FFF9, 32'hFFFF_FFF9, 1, 1, 0);

      // Reset while a result is held
      push(32'd42, 1'b1, 0);
      out_ready = 1'b0;
      chk("donerst valid_pre", 64'(a_out_valid), 64'd1);
      rst = 1'b1;
      tick();
      chk("donerst valid", 64'(a_out_valid), 64'd0);
      chk("donerst min", 64'(a_out_min), 64'd0);
      chk("donerst count", 64'(a_out_count), 64'd0);
      chk("donerst in_ready", 64'(a_in_ready), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("donerst idle", 64'(a_out_valid), 64'd0);

      // Count saturation (C=4 instance) with 0..19
      for (int i = 0; i < 20; i++)
         push(32'(i), i == 19, 0);
      get_result("sat", 32'd0, 32'd19, 20, 15, 0);

      // Random packets vs reference model
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 24);
         s.delete();
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 7))
               0:       s.push_back(32'h8000_0000);
               1:       s.push_back(32'h7FFF_FFFF);
               2:       s.push_back(32'($urandom_range(0, 3)) - 32'd2);
               default: s.push_back($urandom);
            endcase
         end
         mn = s[0];
         mx = s[0];
         foreach (s[i]) begin
            if ($signed(s[i]) < mn) mn = s[i];
            if ($signed(s[i]) > mx) mx = s[i];
         end
         sat = (len > 15) ? 15 : len;
         foreach (s[i])
            push(s[i], i == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
         get_result($sformatf("rnd%0d", p), mn, mx, len, sat, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
